wbdepp_arbiter: RTL and testbench
=================================

Name: wbdepp_arbiter

Overview:
- Two-master Wishbone (pipelined) arbiter.
- Shares the single bus master port of the design between the DEPP parallel-port bridge (master A, host access) and the on-chip engine master (master B, e.g. DWT/lifting engine).
- Grants are held for a whole bus cycle (CYC). Fairness is round-robin.
- A watchdog aborts cycles the slave never answers, so neither master can hang the bus.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, cycles with outstanding requests and no ACK/ERR before abort; must be >= 2.
- CNTW, 4, width of the outstanding-request counter.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_a_cyc, i_a_stb, i_a_we  in  1 each  master A (DEPP bridge) cycle/strobe/write
- i_a_addr  in  AW  master A address
- i_a_data  in  DW  master A write data
- o_a_ack, o_a_stall, o_a_err  out  1 each  master A responses
- o_a_data  out  DW  master A read data
- i_b_cyc, i_b_stb, i_b_we, i_b_addr, i_b_data  in  1/1/1/AW/DW  master B request, same meaning as A
- o_b_ack, o_b_stall, o_b_err, o_b_data  out  1/1/1/DW  master B responses
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  slave-side bus controls
- o_wb_addr  out  AW  slave-side address
- o_wb_data  out  DW  slave-side write data
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave responses
- i_wb_data  in  DW  slave read data
- o_owner  out  2  00 none, 01 A, 10 B
- o_timeout  out  1  sticky abort flag; cleared at next grant

Behaviour:
- Reset:
  - State IDLE, owner none, last-owner B (so A wins the first tie).
  - Counters 0, o_timeout 0.
  - All o_wb_* 0; all ack/err 0; both stalls follow the non-owner rule.
- States: IDLE, OWN_A, OWN_B, ABORT, DRAIN.
- IDLE:
  - Only i_a_cyc: go OWN_A next edge.
  - Only i_b_cyc: go OWN_B next edge.
  - Both: grant the master that was not last owner.
  - Grant latency is 1 cycle from CYC rise to o_owner change.
- OWN_x:
  - o_wb_cyc = i_x_cyc; o_wb_stb/we/addr/data = master x's inputs, combinational.
  - o_x_stall = i_wb_stall; o_x_ack = i_wb_ack; o_x_err = i_wb_err.
  - When i_x_cyc falls:
    - Other master's CYC high: hand off directly to OWN_other next edge (one idle bus cycle, o_wb_cyc=0).
    - Otherwise: go IDLE.
  - Grant never changes while the owner's CYC is high.
- Non-owner master:
  - o_stall = 1.
  - ack = 0, err = 0.
  - STB is held off and never reaches the bus.
- Read data: o_a_data = o_b_data = i_wb_data; only the owner sees ACK.
- Outstanding counter:
  - +1 on o_wb_stb & !i_wb_stall; -1 on i_wb_ack | i_wb_err.
  - Simultaneous issue and response: unchanged.
  - Owner issues a new STB with counter at max: stall forced 1 to that owner.
  - Reset to 0 on every grant change.
- Watchdog:
  - Counts while counter > 0 and no ACK/ERR; clears on any ACK/ERR or when counter reaches 0.
  - Reaching TIMEOUT: go ABORT.
- ABORT (1 cycle):
  - o_wb_cyc = o_wb_stb = 0.
  - Owner gets o_err = 1 for exactly this cycle.
  - o_timeout set.
  - Next state DRAIN.
- DRAIN:
  - o_wb_cyc = 0; owner stall = 1; ACK/ERR from slave ignored.
  - Leave to IDLE when owner CYC falls.
- Slave ERR in OWN_x: forwarded as-is; counter decrements; grant held until owner drops CYC.
- o_owner reflects OWN_x; reads the aborted owner in ABORT/DRAIN; 00 in IDLE.
- Reset asserted mid-cycle: o_wb_cyc drops asynchronously; pending transfers are discarded.

Test Plan:
- Single A write: A CYC/STB addr 0x10 data 0xDEADBEEF, slave ACK after 2 cycles -> o_owner=01 one cycle after CYC, bus shows 0x10/0xDEADBEEF, o_a_ack one pulse, o_b_stall=1 throughout.
- Contention from reset: A and B raise CYC same cycle -> A granted first; after A drops CYC, B granted after exactly one o_wb_cyc=0 cycle. Next simultaneous request -> B wins.
- Pipelined reads: B issues 4 STBs, slave stalls 1 cycle then ACKs with 0x1,0x2,0x3,0x4 -> o_b_data matches in order, 4 acks, counter returns 0, grant kept until B CYC falls.
- Timeout: A issues 1 STB, slave never ACKs, TIMEOUT=8 -> after 8 cycles o_wb_cyc=0, o_a_err pulse 1 cycle, o_timeout=1; late i_wb_ack ignored; B then granted and o_timeout clears.
- Async reset mid-cycle: drop i_rst_n during OWN_B with 2 outstanding -> o_wb_cyc=0 immediately, o_owner=00; after release, B still requesting -> regranted one edge later.

Source files
------------

// File: rtl/wbdepp_arbiter.sv
// Two-master pipelined Wishbone arbiter: DEPP bridge (A) and engine (B) share one bus,
// round-robin grants held for a whole CYC, with a watchdog that aborts unanswered cycles.
module wbdepp_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ack,
  output logic          o_a_stall,
  output logic          o_a_err,
  output logic [DW-1:0] o_a_data,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ack,
  output logic          o_b_stall,
  output logic          o_b_err,
  output logic [DW-1:0] o_b_data,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data,
  output logic [1:0]    o_owner,
  output logic          o_timeout
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_OWN_A, S_OWN_B, S_ABORT, S_DRAIN} state_t;

  state_t          state_q, state_d;
  // own_b_q doubles as the last-owner record used for round-robin in IDLE
  logic            own_b_q, own_b_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            to_q, to_d;

  logic own_cyc, oth_cyc, own_stb, active, full, issue, resp;
  logic own_stall, own_ack, own_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      own_b_q <= 1'b1;
      cnt_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      own_b_q <= own_b_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    own_cyc   = own_b_q ? i_b_cyc : i_a_cyc;
    oth_cyc   = own_b_q ? i_a_cyc : i_b_cyc;
    own_stb   = own_b_q ? i_b_stb : i_a_stb;
    active    = (state_q == S_OWN_A) || (state_q == S_OWN_B);
    full      = &cnt_q;

    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    own_stall = 1'b1;
    own_ack   = 1'b0;
    own_err   = 1'b0;

    if (active) begin
      o_wb_cyc  = own_cyc;
      // A strobe offered while the counter is full is held off the bus and stalled
      o_wb_stb  = own_cyc & own_stb & ~full;
      o_wb_we   = own_b_q ? i_b_we   : i_a_we;
      o_wb_addr = own_b_q ? i_b_addr : i_a_addr;
      o_wb_data = own_b_q ? i_b_data : i_a_data;
      own_stall = i_wb_stall | full;
      own_ack   = i_wb_ack;
      own_err   = i_wb_err;
    end else if (state_q == S_ABORT) begin
      own_err   = 1'b1;
    end

    o_a_stall = 1'b1;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_stall = 1'b1;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    if (state_q != S_IDLE) begin
      if (own_b_q) begin
        o_b_stall = own_stall;
        o_b_ack   = own_ack;
        o_b_err   = own_err;
      end else begin
        o_a_stall = own_stall;
        o_a_ack   = own_ack;
        o_a_err   = own_err;
      end
    end

    o_a_data  = i_wb_data;
    o_b_data  = i_wb_data;
    o_owner   = (state_q == S_IDLE) ? 2'b00 : (own_b_q ? 2'b10 : 2'b01);
    o_timeout = to_q;

    issue = o_wb_stb & ~i_wb_stall;
    resp  = active & (i_wb_ack | i_wb_err);

    state_d = state_q;
    own_b_d = own_b_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    to_d    = to_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        wd_d  = '0;
        if (i_a_cyc && (!i_b_cyc || own_b_q)) begin
          state_d = S_OWN_A;
          own_b_d = 1'b0;
          to_d    = 1'b0;
        end else if (i_b_cyc) begin
          state_d = S_OWN_B;
          own_b_d = 1'b1;
          to_d    = 1'b0;
        end
      end
      S_OWN_A, S_OWN_B: begin
        if (!own_cyc) begin
          cnt_d = '0;
          wd_d  = '0;
          if (oth_cyc) begin
            state_d = own_b_q ? S_OWN_A : S_OWN_B;
            own_b_d = ~own_b_q;
            to_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (issue && !resp)
            cnt_d = cnt_q + 1'b1;
          else if (!issue && resp && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
          wd_d = ((cnt_q != '0) && !resp) ? wd_q + 1'b1 : '0;
          if (wd_d == WD_MAX) begin
            state_d = S_ABORT;
            to_d    = 1'b1;
            cnt_d   = '0;
            wd_d    = '0;
          end
        end
      end
      S_ABORT: state_d = S_DRAIN;
      S_DRAIN: if (!own_cyc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wbdepp_arbiter.sv
// Directed bench for wbdepp_arbiter: a behavioural ownership model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_wbdepp_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_cyc = 0, a_stb = 0, a_we = 0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdat = '0;
  logic          b_cyc = 0, b_stb = 0, b_we = 0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdat = '0;
  logic          wb_ack = 0, wb_stall = 0, wb_err = 0;
  logic [DW-1:0] wb_rdat = '0;

  logic          a_ack, a_stall, a_err, b_ack, b_stall, b_err;
  logic [DW-1:0] a_rdat, b_rdat;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdat;
  logic [1:0]    owner;
  logic          timeout;

  int n_cmp = 0;
  int n_bad = 0;

  wbdepp_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CNTW(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_wdat),
    .o_a_ack(a_ack), .o_a_stall(a_stall), .o_a_err(a_err), .o_a_data(a_rdat),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_wdat),
    .o_b_ack(b_ack), .o_b_stall(b_stall), .o_b_err(b_err), .o_b_data(b_rdat),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdat),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .i_wb_err(wb_err), .i_wb_data(wb_rdat),
    .o_owner(owner), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner 0 none / 1 A / 2 B; phase 0 normal / 1 abort / 2 drain
  typedef struct packed {
    logic [1:0] owner;
    logic [1:0] last;
    logic [1:0] phase;
    int         out;
    int         wd;
    logic       to;
  } mstate_t;

  localparam mstate_t M_RST = '{owner: 2'd0, last: 2'd2, phase: 2'd0, out: 0, wd: 0, to: 1'b0};
  mstate_t m = M_RST;

  function automatic mstate_t grant(input mstate_t s, input logic [1:0] who);
    mstate_t n = s;
    n.owner = who; n.last = who; n.phase = 2'd0; n.out = 0; n.wd = 0; n.to = 1'b0;
    return n;
  endfunction

  function automatic mstate_t m_next(input mstate_t s);
    mstate_t n = s;
    logic xcyc, ocyc, xstb;
    int issue, resp;
    xcyc = (s.owner == 2'd2) ? b_cyc : a_cyc;
    ocyc = (s.owner == 2'd2) ? a_cyc : b_cyc;
    xstb = (s.owner == 2'd2) ? b_stb : a_stb;
    if (s.owner == 2'd0) begin
      if (a_cyc && (!b_cyc || s.last == 2'd2)) n = grant(s, 2'd1);
      else if (b_cyc) n = grant(s, 2'd2);
    end else if (s.phase == 2'd1) begin
      n.phase = 2'd2;
    end else if (s.phase == 2'd2) begin
      if (!xcyc) begin n.owner = 2'd0; n.phase = 2'd0; end
    end else if (!xcyc) begin
      n.out = 0; n.wd = 0;
      if (ocyc) n = grant(s, (s.owner == 2'd1) ? 2'd2 : 2'd1);
      else n.owner = 2'd0;
    end else begin
      issue = (xstb && s.out != 15 && !wb_stall) ? 1 : 0;
      resp  = (wb_ack || wb_err) ? 1 : 0;
      n.out = s.out + issue - resp;
      if (n.out < 0) n.out = 0;
      n.wd = (s.out > 0 && resp == 0) ? s.wd + 1 : 0;
      if (n.wd == TO) begin n.phase = 2'd1; n.to = 1'b1; n.out = 0; n.wd = 0; end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RST;
    else m <= m_next(m);
  end

  task automatic compare_model();
    logic act, isb, xcyc, xstb, full;
    logic e_cyc, e_stb, e_we, ox_stall, ox_ack, ox_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    act  = (m.owner != 2'd0) && (m.phase == 2'd0);
    isb  = (m.owner == 2'd2);
    xcyc = isb ? b_cyc : a_cyc;
    xstb = isb ? b_stb : a_stb;
    full = (m.out == 15);
    e_cyc = act && xcyc;
    e_stb = act && xcyc && xstb && !full;
    e_we   = act ? (isb ? b_we : a_we) : 1'b0;
    e_addr = act ? (isb ? b_addr : a_addr) : '0;
    e_wd   = act ? (isb ? b_wdat : a_wdat) : '0;
    ox_stall = act ? (wb_stall || full) : 1'b1;
    ox_ack   = act && wb_ack;
    ox_err   = act ? wb_err : (m.phase == 2'd1);
    check("owner", owner, m.owner);
    check("timeout", timeout, m.to);
    check("wb_cyc", wb_cyc, e_cyc);
    check("wb_stb", wb_stb, e_stb);
    check("wb_we", wb_we, e_we);
    check("wb_addr", wb_addr, e_addr);
    check("wb_data", wb_wdat, e_wd);
    check("a_stall", a_stall, (m.owner == 2'd1) ? ox_stall : 1'b1);
    check("a_ack", a_ack, (m.owner == 2'd1) ? ox_ack : 1'b0);
    check("a_err", a_err, (m.owner == 2'd1) ? ox_err : 1'b0);
    check("b_stall", b_stall, (m.owner == 2'd2) ? ox_stall : 1'b1);
    check("b_ack", b_ack, (m.owner == 2'd2) ? ox_ack : 1'b0);
    check("b_err", b_err, (m.owner == 2'd2) ? ox_err : 1'b0);
    check("a_rdata", a_rdat, wb_rdat);
    check("b_rdata", b_rdat, wb_rdat);
  endtask

  always @(negedge clk) compare_model();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL run_bound: got no finish, expected finish within 200000");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_owner", owner, 2'b00);
    check("rst_wb_cyc", wb_cyc, 1'b0);
    check("rst_a_stall", a_stall, 1'b1);
    check("rst_b_stall", b_stall, 1'b1);
    check("rst_timeout", timeout, 1'b0);
    tick();
    rst_n = 1'b1;

    // contention from reset: A first, then direct hand-off to B
    tick(); a_cyc = 1; b_cyc = 1;
    @(negedge clk); check("cont_idle_owner", owner, 2'b00);
    tick(); @(negedge clk); check("cont_owner_a", owner, 2'b01);
    tick(); a_cyc = 0;
    @(negedge clk); check("handoff_gap_cyc", wb_cyc, 1'b0);
    tick(); @(negedge clk);
    check("handoff_owner_b", owner, 2'b10);
    check("handoff_cyc_b", wb_cyc, 1'b1);
    tick(); b_cyc = 0;
    tick();

    // single A write
    a_cyc = 1; a_stb = 1; a_we = 1; a_addr = 32'h10; a_wdat = 32'hDEADBEEF;
    tick(); @(negedge clk);
    check("wr_owner", owner, 2'b01);
    check("wr_addr", wb_addr, 32'h10);
    check("wr_data", wb_wdat, 32'hDEADBEEF);
    check("wr_b_stall", b_stall, 1'b1);
    tick(); a_stb = 0;
    tick(); wb_ack = 1;
    @(negedge clk); check("wr_a_ack", a_ack, 1'b1);
    tick(); wb_ack = 0; a_cyc = 0; a_we = 0;
    @(negedge clk); check("wr_a_ack_end", a_ack, 1'b0);
    tick();

    // simultaneous request after A owned last: B wins; pipelined reads
    a_cyc = 1; b_cyc = 1; b_stb = 1; b_addr = 32'h100; wb_stall = 1;
    tick(); @(negedge clk); check("rr_owner_b", owner, 2'b10);
    for (int k = 0; k < 5; k++) begin
      tick();
      wb_stall = 0;
      b_stb = (k < 4);
      b_addr = 32'h100 + 32'(4 * k);
      wb_ack = (k >= 1);
      wb_rdat = 32'(k);
      @(negedge clk);
      if (k >= 1) begin
        check("rd_b_ack", b_ack, 1'b1);
        check("rd_b_data", b_rdat, 32'(k));
      end
    end
    tick(); wb_ack = 0; wb_rdat = '0; b_addr = '0;
    repeat (10) tick();
    @(negedge clk);
    check("rd_grant_held", owner, 2'b10);
    check("rd_a_stall", a_stall, 1'b1);

    // B releases, A waiting takes over; then watchdog timeout on A
    tick(); b_cyc = 0;
    @(negedge clk); check("ho2_gap_cyc", wb_cyc, 1'b0);
    tick(); @(negedge clk); check("ho2_owner_a", owner, 2'b01);
    tick(); a_stb = 1; a_addr = 32'h20;
    tick(); a_stb = 0; b_cyc = 1;
    repeat (7) tick();
    @(negedge clk);
    check("to_pre_cyc", wb_cyc, 1'b1);
    check("to_pre_err", a_err, 1'b0);
    tick(); @(negedge clk);
    check("to_abort_cyc", wb_cyc, 1'b0);
    check("to_abort_err", a_err, 1'b1);
    check("to_flag", timeout, 1'b1);
    check("to_owner", owner, 2'b01);
    tick(); wb_ack = 1;
    @(negedge clk);
    check("drain_late_ack", a_ack, 1'b0);
    check("drain_err", a_err, 1'b0);
    check("drain_stall", a_stall, 1'b1);
    tick(); wb_ack = 0; a_cyc = 0;
    tick(); @(negedge clk);
    check("post_to_idle", owner, 2'b00);
    check("post_to_flag", timeout, 1'b1);
    tick(); @(negedge clk);
    check("post_to_owner_b", owner, 2'b10);
    check("post_to_clear", timeout, 1'b0);

    // async reset with two outstanding B transfers
    tick(); b_stb = 1; b_addr = 32'h200;
    tick(); b_addr = 32'h204;
    tick(); b_stb = 0;
    @(negedge clk); check("pre_rst_cyc", wb_cyc, 1'b1);
    #2 rst_n = 0;
    #1;
    check("arst_cyc", wb_cyc, 1'b0);
    check("arst_owner", owner, 2'b00);
    tick(); rst_n = 1;
    @(negedge clk); check("arst_rel_idle", owner, 2'b00);
    tick(); @(negedge clk); check("arst_regrant", owner, 2'b10);
    tick(); b_cyc = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
